// File: rtl/factor_pkg.sv
// factor_pkg -- shared definitions for the factor scanner and the downstream
// digit-cycling display controller.
//   NUMBER_W            operand width
//   DEFAULT_MAX_DIVISOR default highest trial divisor
//   factor_w()          factor mask width for a given highest divisor
//   FACTOR_W            factor mask width at the default highest divisor
//   state_e             scanner FSM states
package factor_pkg;

  localparam int NUMBER_W            = 8;
  localparam int DEFAULT_MAX_DIVISOR = 19;

  // One mask bit per trial divisor 2..max_divisor.
  function automatic int factor_w(input int max_divisor);
    return max_divisor - 1;
  endfunction

  localparam int FACTOR_W = factor_w(DEFAULT_MAX_DIVISOR);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_SCAN  = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

endpackage

// File: rtl/factor_scanner_div_step.sv
// div_step -- one bit of a restoring division, purely combinational.
//   rem_i      [7:0]  partial remainder, always < d_i
//   in_bit_i          next dividend bit, MSB first
//   d_i        [7:0]  divisor
//   rem_next_o [7:0]  updated partial remainder, always < d_i
module div_step
  import factor_pkg::*;
(
  input  logic [NUMBER_W-1:0] rem_i,
  input  logic                in_bit_i,
  input  logic [NUMBER_W-1:0] d_i,
  output logic [NUMBER_W-1:0] rem_next_o
);

  // The shifted remainder can reach 2*d-1, so it needs one extra bit.
  logic [NUMBER_W:0] t;
  logic [NUMBER_W:0] res;
  logic              unused_res_msb;

  always_comb begin
    t   = {rem_i, in_bit_i};
    res = t;
    if (t >= {1'b0, d_i}) begin
      res = t - {1'b0, d_i};
    end
  end

  // Result is always < d, so the top bit is zero and can be dropped.
  assign rem_next_o     = res[NUMBER_W-1:0];
  assign unused_res_msb = res[NUMBER_W];

endmodule

// File: rtl/factor_scanner.sv
// factor_scanner -- sequential trial-division factor finder for an 8-bit
// operand. Each divisor 2..MAX_DIVISOR is tested with eight restoring-division
// steps; the finished mask is published atomically with valid.
//   clk      clock, rising edge
//   reset    synchronous, active-high
//   number   operand, treated as static switch data
//   factors  bit i set iff (i+2) divides the latched operand (registered)
//   valid    factors matches the latched operand
//   busy     scan in progress
// Optional build macro FACTOR_SCANNER_EARLY_EXIT_EN: commit as soon as the
// divisor exceeds the operand instead of running the full fixed-length scan.
module factor_scanner
  import factor_pkg::*;
#(
  parameter int MAX_DIVISOR = DEFAULT_MAX_DIVISOR
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUMBER_W-1:0]                number,
  output logic [factor_w(MAX_DIVISOR)-1:0]   factors,
  output logic                               valid,
  output logic                               busy
);

  localparam int                  FW    = factor_w(MAX_DIVISOR);
  localparam logic [NUMBER_W-1:0] MAX_D = NUMBER_W'(MAX_DIVISOR);

  state_e              state_q,   state_d;
  logic [NUMBER_W-1:0] num_q,     num_d;
  logic [NUMBER_W-1:0] div_q,     div_d;
  logic [2:0]          bit_q,     bit_d;
  logic [NUMBER_W-1:0] rem_q,     rem_d;
  logic [FW-1:0]       mask_q,    mask_d;
  logic [FW-1:0]       factors_q, factors_d;
  logic                valid_q,   valid_d;
  logic                busy_q,    busy_d;

  logic [NUMBER_W-1:0] rem_next;
  logic                restart;
  logic [FW-1:0]       mask_set;

  div_step u_div_step (
    .rem_i      (rem_q),
    .in_bit_i   (num_q[bit_q]),
    .d_i        (div_q),
    .rem_next_o (rem_next)
  );

  // Operand change is checked in every state so a mid-scan change restarts.
  assign restart  = (state_q == ST_START) || (number != num_q);
  // Mask with the current divisor's result folded in; each bit is written once
  // per scan and the mask starts at zero, so OR-ing is enough.
  assign mask_set = mask_q | (FW'(rem_next == '0) << (div_q - NUMBER_W'(2)));

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    div_d     = div_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    mask_d    = mask_q;
    factors_d = factors_q;
    valid_d   = valid_q;
    busy_d    = busy_q;

    if (restart) begin
      // Restart wins over any commit on the same edge; factors keeps old data.
      num_d   = number;
      div_d   = NUMBER_W'(2);
      bit_d   = 3'd7;
      rem_d   = '0;
      mask_d  = '0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      state_d = ST_SCAN;
    end else if (state_q == ST_SCAN) begin
`ifdef FACTOR_SCANNER_EARLY_EXIT_EN
      if ((bit_q == 3'd7) && (div_q > num_q)) begin
        // No larger divisor can divide the operand; untested bits stay zero.
        factors_d = (num_q < NUMBER_W'(2)) ? '0 : mask_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end else begin
`endif
        rem_d = rem_next;
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) begin
          mask_d = mask_set;
          rem_d  = '0;
          bit_d  = 3'd7;
          div_d  = div_q + NUMBER_W'(1);
          if (div_q == MAX_D) begin
            factors_d = (num_q < NUMBER_W'(2)) ? '0 : mask_set;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end
`ifdef FACTOR_SCANNER_EARLY_EXIT_EN
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_START;
      num_q     <= '0;
      factors_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      factors_q <= factors_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Working registers are always initialised by the restart that follows reset.
  always_ff @(posedge clk) begin
    div_q  <= div_d;
    bit_q  <= bit_d;
    rem_q  <= rem_d;
    mask_q <= mask_d;
  end

  assign factors = factors_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_factor_scanner.sv
module tb_factor_scanner;

  localparam int MAXD = 19;
  localparam int FW   = MAXD - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    number;
  logic [FW-1:0] factors;
  logic          valid;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  factor_scanner #(.MAX_DIVISOR(MAXD)) dut (
    .clk     (clk),
    .reset   (reset),
    .number  (number),
    .factors (factors),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int n);
`ifdef FACTOR_SCANNER_EARLY_EXIT_EN
    if (n < 2) return 1;
    if (n < MAXD) return 8 * (n - 1) + 1;
    return 8 * (MAXD - 1);
`else
    return 8 * (MAXD - 1) + 0 * n;
`endif
  endfunction

  // Counts edges after the current negedge until valid is seen (bounded).
  task automatic wait_valid(output int edges);
    edges = 0;
    while (valid !== 1'b1 && edges < 400) begin
      @(negedge clk);
      edges++;
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1 && valid === 1'b1) begin
      failures++;
      $display("FAIL busy_valid_overlap: busy=%0b valid=%0b required not both high", busy, valid);
    end
  end

  task automatic test_reset();
    int e;
    logic held_bad;
    reset  = 1'b1;
    number = 8'd12;
    repeat (3) @(negedge clk);
    checks++; if (factors !== '0) begin failures++; $display("FAIL reset_factors: got %h required 0", factors); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b required 0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_edge_busy: got %0b required 1", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL first_edge_valid: got %0b required 0", valid); end
    wait_valid(e);
    checks++; if (e != exp_lat(12)) begin failures++; $display("FAIL lat_12: got %0d required %0d", e, exp_lat(12)); end
    checks++; if (factors !== 18'h00417) begin failures++; $display("FAIL factors_12: got %h required 00417", factors); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_12: got %0b required 0", busy); end
    held_bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (valid !== 1'b1 || busy !== 1'b0 || factors !== 18'h00417) held_bad = 1'b1;
    end
    checks++; if (held_bad !== 1'b0) begin failures++; $display("FAIL idle_hold_12: got %0b required 0", held_bad); end
  endtask

  task automatic test_255_17();
    int e;
    logic held_bad;
    number = 8'd255;
    @(negedge clk);
    wait_valid(e);
    checks++; if (e != exp_lat(255)) begin failures++; $display("FAIL lat_255: got %0d required %0d", e, exp_lat(255)); end
    checks++; if (factors !== 18'h0A00A) begin failures++; $display("FAIL factors_255: got %h required 0a00a", factors); end
    number = 8'd17;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL restart_17_valid: got %0b required 0", valid); end
    e = 0;
    held_bad = 1'b0;
    while (valid !== 1'b1 && e < 400) begin
      if (factors !== 18'h0A00A) held_bad = 1'b1;
      @(negedge clk);
      e++;
    end
    checks++; if (held_bad !== 1'b0) begin failures++; $display("FAIL hold_0a00a: got %0b required 0", held_bad); end
    checks++; if (e != exp_lat(17)) begin failures++; $display("FAIL lat_17: got %0d required %0d", e, exp_lat(17)); end
    checks++; if (factors !== 18'h08000) begin failures++; $display("FAIL factors_17: got %h required 08000", factors); end
  endtask

  task automatic test_zero_one();
    int e;
    number = 8'd0;
    @(negedge clk);
    wait_valid(e);
    checks++; if (e != exp_lat(0)) begin failures++; $display("FAIL lat_0: got %0d required %0d", e, exp_lat(0)); end
    checks++; if (factors !== '0) begin failures++; $display("FAIL factors_0: got %h required 0", factors); end
    number = 8'd1;
    @(negedge clk);
    wait_valid(e);
    checks++; if (e != exp_lat(1)) begin failures++; $display("FAIL lat_1: got %0d required %0d", e, exp_lat(1)); end
    checks++; if (factors !== '0) begin failures++; $display("FAIL factors_1: got %h required 0", factors); end
  endtask

  task automatic test_change_mid();
    int e;
    logic bad;
    number = 8'd12;
    @(negedge clk);
    bad = 1'b0;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || factors !== '0) bad = 1'b1;
    end
    number = 8'd19;
    @(negedge clk);
    e = 0;
    while (valid !== 1'b1 && e < 400) begin
      if (factors !== '0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      e++;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL change_no_partial: got %0b required 0", bad); end
    checks++; if (e != exp_lat(19)) begin failures++; $display("FAIL lat_change_19: got %0d required %0d", e, exp_lat(19)); end
    checks++; if (factors !== 18'h20000) begin failures++; $display("FAIL factors_19: got %h required 20000", factors); end
  endtask

  task automatic test_reset_mid();
    int e;
    logic bad;
    number = 8'd12;
    @(negedge clk);
    bad = 1'b0;
    repeat (69) begin
      @(negedge clk);
      if (factors !== 18'h20000 || valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL hold_20000: got %0b required 0", bad); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (factors !== '0) begin failures++; $display("FAIL midreset_factors: got %h required 0", factors); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %0b required 0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %0b required 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL post_midreset_busy: got %0b required 1", busy); end
    wait_valid(e);
    checks++; if (e != exp_lat(12)) begin failures++; $display("FAIL lat_post_reset_12: got %0d required %0d", e, exp_lat(12)); end
    checks++; if (factors !== 18'h00417) begin failures++; $display("FAIL factors_post_reset_12: got %h required 00417", factors); end
  endtask

  task automatic test_back_to_back();
    int e;
    number = 8'd6;
    @(negedge clk);
    wait_valid(e);
    checks++; if (e != exp_lat(6)) begin failures++; $display("FAIL lat_6: got %0d required %0d", e, exp_lat(6)); end
    checks++; if (factors !== 18'h00013) begin failures++; $display("FAIL factors_6: got %h required 00013", factors); end
    number = 8'd200;
    @(negedge clk);
    wait_valid(e);
    checks++; if (e != exp_lat(200)) begin failures++; $display("FAIL lat_200: got %0d required %0d", e, exp_lat(200)); end
    checks++; if (factors !== 18'h0014D) begin failures++; $display("FAIL factors_200: got %h required 0014d", factors); end
    number = 8'd7;
    @(negedge clk);
    wait_valid(e);
    checks++; if (e != exp_lat(7)) begin failures++; $display("FAIL lat_7: got %0d required %0d", e, exp_lat(7)); end
    checks++; if (factors !== 18'h00020) begin failures++; $display("FAIL factors_7: got %h required 00020", factors); end
  endtask

  initial begin
    reset  = 1'b1;
    number = 8'd0;
    test_reset();
    test_255_17();
    test_zero_one();
    test_change_mid();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
